// File: rtl/mdom_scdb_hdr_arbiter.sv
// Round-robin arbiter sharing the scdb header path among the capture channels.
// Registers the winning header, stamps its channel index, and locks partial headers.
module mdom_scdb_hdr_arbiter #(
  parameter int N_CHAN       = 24,
  parameter int BUNDLE_W     = 113,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CHAN-1:0]            req_valid,
  input  logic [N_CHAN*BUNDLE_W-1:0]   req_bundle,
  output logic [N_CHAN-1:0]            req_ack,
  output logic                         out_valid,
  output logic [BUNDLE_W-1:0]          out_bundle,
  input  logic                         out_ready,
  output logic [4:0]                   grant_idx,
  output logic                         lock_active,
  output logic                         lock_timeout
);

  localparam int CNT_W       = $clog2(LOCK_TIMEOUT) + 1;
  localparam int IDX_MSB     = BUNDLE_W - 1;
  localparam int PARTIAL_BIT = 106;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        rr_ptr_q, rr_ptr_d;
  logic [4:0]        lock_ch_q, lock_ch_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              lock_timeout_q, lock_timeout_d;

  logic              out_valid_q;
  logic [BUNDLE_W-1:0] out_bundle_q;
  logic [4:0]        grant_q;
  logic [N_CHAN-1:0] req_ack_q;

  logic [31:0]         req_pad;
  logic [BUNDLE_W-1:0] bundle_arr [32];
  logic [4:0]          arb_idx;
  logic                arb_found;
  logic [4:0]          sel_ch;
  logic                sel_req;
  logic [BUNDLE_W-1:0] sel_bundle;
  logic [BUNDLE_W-1:0] stamped;
  logic                cap_en;
  logic                capture;
  logic                timeout_hit;

  function automatic logic [4:0] ptr_after(input logic [4:0] idx);
    return (idx == 5'(N_CHAN - 1)) ? 5'd0 : idx + 5'd1;
  endfunction

  // Pad to 32 channels so a 5-bit index can select without range concerns.
  assign req_pad = 32'(req_valid);

  always_comb begin
    for (int c = 0; c < 32; c++) bundle_arr[c] = '0;
    for (int c = 0; c < N_CHAN; c++) bundle_arr[c] = req_bundle[c*BUNDLE_W +: BUNDLE_W];
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      logic [5:0] pos;
      pos = {1'b0, rr_ptr_q} + 6'(i);
      if (pos >= 6'(N_CHAN)) pos = pos - 6'(N_CHAN);
      if (!arb_found && req_pad[pos[4:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos[4:0];
      end
    end
  end

  assign cap_en      = !out_valid_q || out_ready;
  assign sel_ch      = (state_q == S_LOCK) ? lock_ch_q : arb_idx;
  assign sel_req     = (state_q == S_LOCK) ? req_pad[lock_ch_q] : arb_found;
  assign sel_bundle  = bundle_arr[sel_ch];
  assign timeout_hit = (state_q == S_LOCK) && !req_pad[lock_ch_q] && (lock_cnt_q >= CNT_LAST);
  assign capture     = cap_en && sel_req;

  always_comb begin
    stamped = sel_bundle;
    stamped[IDX_MSB -: 5] = sel_ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_ARB;
      rr_ptr_q       <= '0;
      lock_ch_q      <= '0;
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_ch_q      <= lock_ch_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    lock_ch_d      = lock_ch_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = 1'b0;
    case (state_q)
      S_ARB: begin
        lock_cnt_d = '0;
        if (capture) begin
          rr_ptr_d = ptr_after(arb_idx);
          if (sel_bundle[PARTIAL_BIT]) begin
            state_d   = S_LOCK;
            lock_ch_d = arb_idx;
          end
        end
      end
      S_LOCK: begin
        if (timeout_hit) begin
          state_d        = S_ARB;
          lock_timeout_d = 1'b1;
          lock_cnt_d     = '0;
          rr_ptr_d       = ptr_after(lock_ch_q);
        end else if (capture) begin
          lock_cnt_d = '0;
          if (!sel_bundle[PARTIAL_BIT]) begin
            state_d  = S_ARB;
            rr_ptr_d = ptr_after(lock_ch_q);
          end
        end else if (!req_pad[lock_ch_q] && (lock_cnt_q != '1)) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  always_comb begin
    lock_active  = (state_q == S_LOCK);
    lock_timeout = lock_timeout_q;
  end

  // A held header stays frozen while the FIFO back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      grant_q      <= '0;
      req_ack_q    <= '0;
    end else begin
      req_ack_q <= '0;
      if (capture) begin
        out_valid_q  <= 1'b1;
        out_bundle_q <= stamped;
        grant_q      <= sel_ch;
        req_ack_q    <= N_CHAN'(1) << sel_ch;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bundle = out_bundle_q;
  assign grant_idx  = grant_q;
  assign req_ack    = req_ack_q;

endmodule

// File: tb/tb_mdom_scdb_hdr_arbiter.sv
// Directed bench for mdom_scdb_hdr_arbiter: vector table plus hand sequences
// for backpressure, locking, lock timeout, field stamping and async reset.
module tb_mdom_scdb_hdr_arbiter;

  localparam int N  = 24;
  localparam int BW = 113;
  localparam int LT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*BW-1:0] req_bundle;
  logic [N-1:0]    req_ack;
  logic            out_valid;
  logic [BW-1:0]   out_bundle;
  logic            out_ready;
  logic [4:0]      grant_idx;
  logic            lock_active;
  logic            lock_timeout;

  logic [BW-1:0]   bund [N];
  int              checks   = 0;
  int              failures = 0;

  typedef struct {
    logic [N-1:0] req;
    logic         exp_valid;
    int           exp_grant;
  } vec_t;

  vec_t tbl [14];

  mdom_scdb_hdr_arbiter #(
    .N_CHAN       (N),
    .BUNDLE_W     (BW),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_bundle   (req_bundle),
    .req_ack      (req_ack),
    .out_valid    (out_valid),
    .out_bundle   (out_bundle),
    .out_ready    (out_ready),
    .grant_idx    (grant_idx),
    .lock_active  (lock_active),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < N; c++) req_bundle[c*BW +: BW] = bund[c];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_bundle(input logic partial);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[106] = partial;
    return r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] stamp(input int g);
    logic [BW-1:0] e;
    e = bund[g];
    e[BW-1 -: 5] = 5'(g);
    return e;
  endfunction

  task automatic expect_grant(input string tag, input int g);
    chk({tag, "_valid"},  128'(out_valid),  128'(1));
    chk({tag, "_ack"},    128'(req_ack),    128'(1) << g);
    chk({tag, "_grant"},  128'(grant_idx),  128'(g));
    chk({tag, "_bundle"}, 128'(out_bundle), 128'(stamp(g)));
  endtask

  task automatic expect_hold(input string tag, input int g);
    chk({tag, "_valid"},  128'(out_valid),  128'(1));
    chk({tag, "_ack"},    128'(req_ack),    128'(0));
    chk({tag, "_grant"},  128'(grant_idx),  128'(g));
    chk({tag, "_bundle"}, 128'(out_bundle), 128'(stamp(g)));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_ack"},   128'(req_ack),   128'(0));
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, "_valid"},   128'(out_valid),    128'(0));
    chk({tag, "_bundle"},  128'(out_bundle),   128'(0));
    chk({tag, "_ack"},     128'(req_ack),      128'(0));
    chk({tag, "_grant"},   128'(grant_idx),    128'(0));
    chk({tag, "_lock"},    128'(lock_active),  128'(0));
    chk({tag, "_timeout"}, 128'(lock_timeout), 128'(0));
  endtask

  initial begin
    int ack_total;

    // Hand-computed grants; rr pointer starts at 0 and follows each winner.
    tbl[0]  = '{24'h000020, 1'b1, 5};
    tbl[1]  = '{24'h000204, 1'b1, 9};
    tbl[2]  = '{24'h800004, 1'b1, 23};
    tbl[3]  = '{24'h000005, 1'b1, 0};
    tbl[4]  = '{24'h000004, 1'b1, 2};
    tbl[5]  = '{24'h00000A, 1'b1, 3};
    tbl[6]  = '{24'h000002, 1'b1, 1};
    tbl[7]  = '{24'h000004, 1'b1, 2};
    tbl[8]  = '{24'h000004, 1'b1, 2};
    tbl[9]  = '{24'h000000, 1'b0, 0};
    tbl[10] = '{24'h800000, 1'b1, 23};
    tbl[11] = '{24'h800001, 1'b1, 0};
    tbl[12] = '{24'h800000, 1'b1, 23};
    tbl[13] = '{24'h000000, 1'b0, 0};

    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) bund[c] = rand_bundle(1'b0);

    repeat (3) @(posedge clk);
    #1;
    expect_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].req;
      tick();
      if (tbl[i].exp_valid) expect_grant($sformatf("vec%0d", i), tbl[i].exp_grant);
      else expect_idle($sformatf("vec%0d", i));
    end
    req_valid = '0;

    // Fairness: every channel requesting, grants sweep 0..23 then wrap to 0.
    ack_total = 0;
    req_valid = '1;
    for (int k = 0; k < 25; k++) begin
      tick();
      expect_grant($sformatf("rr%0d", k), k % N);
      if (k < N) ack_total += $countones(req_ack);
    end
    chk("rr_ack_total", 128'(ack_total), 128'(N));
    req_valid = '0;
    tick();
    expect_idle("rr_idle");

    // Backpressure: ch5 held for 10 stalled cycles, ch6 waits for ready.
    out_ready    = 1'b0;
    req_valid[5] = 1'b1;
    tick();
    expect_grant("bp_first", 5);
    req_valid[5] = 1'b0;
    req_valid[6] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      expect_hold($sformatf("bp_hold%0d", k), 5);
    end
    out_ready = 1'b1;
    tick();
    expect_grant("bp_release", 6);
    req_valid[6] = 1'b0;
    tick();
    expect_idle("bp_idle");

    // Lock: ch3 partial, partial, final while ch4 keeps requesting.
    bund[3] = rand_bundle(1'b1);
    bund[4] = rand_bundle(1'b0);
    req_valid[3] = 1'b1;
    req_valid[4] = 1'b1;
    chk("lock_pre_active", 128'(lock_active), 128'(0));
    tick();
    expect_grant("lock_a", 3);
    chk("lock_a_active", 128'(lock_active), 128'(1));
    bund[3] = rand_bundle(1'b1);
    tick();
    expect_grant("lock_b", 3);
    chk("lock_b_active", 128'(lock_active), 128'(1));
    bund[3] = rand_bundle(1'b0);
    tick();
    expect_grant("lock_c", 3);
    chk("lock_c_active", 128'(lock_active), 128'(0));
    req_valid[3] = 1'b0;
    tick();
    expect_grant("lock_d", 4);
    chk("lock_d_active", 128'(lock_active), 128'(0));
    req_valid[4] = 1'b0;
    tick();
    expect_idle("lock_idle");

    // Timeout: ch7 locks then goes quiet; ch8 waits behind the lock.
    bund[7] = rand_bundle(1'b1);
    bund[8] = rand_bundle(1'b0);
    req_valid[7] = 1'b1;
    req_valid[8] = 1'b1;
    tick();
    expect_grant("to_lock", 7);
    chk("to_lock_active", 128'(lock_active), 128'(1));
    req_valid[7] = 1'b0;
    for (int k = 1; k <= LT; k++) begin
      tick();
      chk($sformatf("to_pulse%0d", k),  128'(lock_timeout), 128'(k == LT));
      chk($sformatf("to_active%0d", k), 128'(lock_active),  128'(k != LT));
      chk($sformatf("to_ack%0d", k),    128'(req_ack),      128'(0));
    end
    tick();
    expect_grant("to_after", 8);
    chk("to_after_pulse", 128'(lock_timeout), 128'(0));
    req_valid[8] = 1'b0;
    tick();
    expect_idle("to_idle");

    // Field integrity: incoming channel_idx of 31 must be replaced by 2.
    req_valid[2] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic [BW-1:0] b;
      b = rand_bundle(1'b0);
      b[BW-1 -: 5] = 5'd31;
      bund[2] = b;
      tick();
      expect_grant($sformatf("field%0d", r), 2);
      chk($sformatf("field%0d_low", r), 128'(out_bundle[107:0]), 128'(b[107:0]));
    end
    req_valid[2] = 1'b0;
    tick();
    expect_idle("field_idle");

    // Async reset while locked and stalled, then scan restarts at ch0.
    bund[3] = rand_bundle(1'b1);
    req_valid[3] = 1'b1;
    tick();
    expect_grant("ar_lock", 3);
    chk("ar_lock_active", 128'(lock_active), 128'(1));
    out_ready = 1'b0;
    bund[3] = rand_bundle(1'b1);
    tick();
    chk("ar_stall_valid",  128'(out_valid),   128'(1));
    chk("ar_stall_ack",    128'(req_ack),     128'(0));
    chk("ar_stall_active", 128'(lock_active), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    expect_zero("ar_async");
    req_valid = '0;
    tick();
    rst          = 1'b0;
    out_ready    = 1'b1;
    bund[0]      = rand_bundle(1'b0);
    bund[20]     = rand_bundle(1'b0);
    req_valid[0]  = 1'b1;
    req_valid[20] = 1'b1;
    tick();
    expect_grant("ar_first", 0);
    req_valid = '0;
    tick();
    expect_idle("ar_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdom_scdb_hdr_arbiter.md
Name: mdom_scdb_hdr_arbiter

Overview:
- Shares the single scdb header path among the per-channel waveform-capture engines of the mDOM.
- Each channel presents a 113-bit header bundle with a valid bit. The block round-robin arbitrates among channels, stamps the channel_idx field, and registers the winner toward the downstream header FIFO using a valid/ready handshake.
- Keeps partial/continued waveform headers from one channel contiguous by locking the grant. A lock timeout prevents starvation.

Parameters:
- N_CHAN, 24, number of requesting channels (1..32).
- BUNDLE_W, 113, header bundle width; the field map is fixed by the scdb header bundle definition.
- LOCK_TIMEOUT, 1024, idle cycles a locked channel may go without requesting before the lock is forcibly released.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_CHAN  per-channel header pending; held until acked.
- req_bundle  input  N_CHAN*BUNDLE_W  channel c occupies bits [c*BUNDLE_W +: BUNDLE_W].
- req_ack  output  N_CHAN  one-hot, one-cycle pulse; the channel's bundle was captured this cycle.
- out_valid  output  1  out_bundle holds a header.
- out_bundle  output  BUNDLE_W  registered header to the FIFO.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- grant_idx  output  5  channel index of the current out_bundle.
- lock_active  output  1  grant is locked to one channel.
- lock_timeout  output  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset values (async, active-high): out_valid=0, out_bundle=0, req_ack=0, grant_idx=0, lock_active=0, lock_timeout=0, rr_ptr=0, lock counter=0. State = ARB.
- Capture condition: cap_en = !out_valid || out_ready. Full throughput is one header per cycle while out_ready stays high. When out_valid && !out_ready, out_bundle and grant_idx must hold stable, and req_ack stays 0.
- Output latency: req_valid seen in cycle t → out_valid and req_ack in cycle t+1 (registered). Never more than one req_ack bit is high in a cycle.
- Bundle pass-through: out_bundle = req_bundle of the winner, except bits [112:108] (channel_idx), which are overwritten with the winner index. All other bits pass unchanged.
- out_valid drop: out_valid falls after a handshake if no request is captured in the same cycle.
- State ARB (unlocked):
  - If cap_en and any req_valid, pick the first requesting channel at or after rr_ptr, wrapping modulo N_CHAN. Capture it and set rr_ptr = winner+1, wrapping to 0 after N_CHAN-1.
  - If the captured bundle has bit 106 (partial_wfm)=1: go to LOCK, lock_ch = winner, lock_active=1 from the next cycle.
- State LOCK:
  - Only req_valid[lock_ch] is eligible; all other channels wait.
  - A captured bundle from lock_ch with bit 106=0 ends the lock: return to ARB with rr_ptr = lock_ch+1. A bundle with bit 106=1 keeps the lock.
  - Lock counter: increments every cycle that req_valid[lock_ch]=0, resets to 0 on each lock_ch capture.
  - When the counter reaches LOCK_TIMEOUT-1 with still no request: pulse lock_timeout, clear lock_active, return to ARB next cycle. No capture occurs in the timeout cycle.
- Boundary conditions:
  - Simultaneous requests resolve purely by rr_ptr order.
  - req_valid dropping without ack is illegal upstream; the block does not check for it.
  - A single requesting channel may win on consecutive cycles.
  - Reset mid-lock or mid-stall discards the held header, with no ack replay.
  - N_CHAN=1 degenerates to a registered pass-through with locking.
- Widths: rr_ptr and lock_ch are 5 bits. The lock counter is clog2(LOCK_TIMEOUT)+1 bits and saturates.

Test Plan:
- Round-robin fairness: all 24 req_valid held high, out_ready=1 → grants 0,1,…,23,0 on consecutive cycles; each out_bundle[112:108] equals its grant; 24 acks total in 24 cycles.
- Backpressure: ch5 requests, out_ready=0 for 10 cycles → out_valid=1, out_bundle constant, only one ack (cycle 1). With ch6 also requesting, ch6 is acked only in the cycle out_ready returns to 1.
- Lock: ch3 bundle with bit106=1, ch3 then continues with bit106=1 and then bit106=0, while ch4 requests continuously → output order ch3,ch3,ch3,ch4; lock_active high over the ch3 sequence and low afterward.
- Timeout: LOCK_TIMEOUT=16, ch7 locks then drops req_valid, ch8 requests → lock_timeout pulses exactly 16 cycles after the last ch7 capture; ch8 is granted on the following cycle.
- Field integrity: random bundles with channel_idx input=31 on ch2 → out_bundle[107:0] bit-exact to the input, out_bundle[112:108]=2.
- Async reset while LOCK is active and out_valid=1 → all outputs 0 immediately, without waiting for clk; after release, ch0 is the first channel scanned.
